// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder: takes a WIDTH-bit word over load/ready and emits it
// MSB-first, one bit per clock, on out. Back-to-back words stream with no gap.
module seq_serializer #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             done
);

    // The FSM state is exactly the out_valid flag, so out_valid doubles as the state probe.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             last;
    logic             accept;

    // Handshake: a word transfers on a rising edge where load && ready. ready depends
    // only on registered state; a source must hold load and din until it sees ready.
    assign out_valid = (state_q == SHIFT);
    assign last      = out_valid && (cnt_q == '0);
    assign ready     = !out_valid || last;
    assign done      = last;
    assign out       = out_q;
    assign accept    = load && ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (accept) begin
            // Accepting on the last bit keeps the stream contiguous across words.
            shreg_d = din << 1;
            out_d   = din[WIDTH-1];
            cnt_d   = CW'(WIDTH - 1);
            state_d = SHIFT;
        end else if (out_valid && !last) begin
            out_d   = shreg_q[WIDTH-1];
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - CW'(1);
        end else if (last) begin
            out_d   = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: directed vector table, a WIDTH=4 sequence, and random
// traffic checked against a bit-queue reference model.
module tb_seq_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] din = '0;
    logic         load = 1'b0;
    logic         ready, out, out_valid, done;

    logic [3:0]   din4 = '0;
    logic         load4 = 1'b0;
    logic         ready4, out4, out_valid4, done4;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: bits still owed on out, front entry is the bit on out now.
    logic exp_q[$];

    typedef struct {
        logic         rst;
        logic         ld;
        logic [W-1:0] d;
        logic         e_out;
        logic         e_valid;
        logic         e_done;
        logic         e_ready;
    } vec_t;
    vec_t vecs[$];

    logic w4_out[5]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic w4_valid[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic w4_done[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic w4_ready[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    seq_serializer #(.WIDTH(W), .CW(5)) u_dut (
        .clk(clk), .reset(reset), .din(din), .load(load),
        .ready(ready), .out(out), .out_valid(out_valid), .done(done)
    );

    seq_serializer #(.WIDTH(4), .CW(3)) u_dut4 (
        .clk(clk), .reset(reset), .din(din4), .load(load4),
        .ready(ready4), .out(out4), .out_valid(out_valid4), .done(done4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic void add(input logic rst, input logic ld, input logic [W-1:0] d,
                                input logic o, input logic v, input logic dn, input logic r);
        vec_t x;
        x.rst = rst; x.ld = ld; x.d = d;
        x.e_out = o; x.e_valid = v; x.e_done = dn; x.e_ready = r;
        vecs.push_back(x);
    endfunction

    // Drive one cycle's inputs, advance the model across the edge, check the 8-bit DUT.
    task automatic cycle(input logic rst, input logic ld, input logic [W-1:0] d,
                         input logic ld4, input logic [3:0] d4);
        logic rdy;
        reset = rst; load = ld; din = d; load4 = ld4; din4 = d4;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            rdy = (exp_q.size() <= 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (ld && rdy) for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
        end
        #1;
        check("model_valid", out_valid, exp_q.size() > 0);
        check("model_out", out, (exp_q.size() > 0) ? exp_q[0] : 1'b0);
        check("model_done", done, exp_q.size() == 1);
        check("model_ready", ready, exp_q.size() <= 1);
    endtask

    initial begin
        // Reset then idle; reset wins over load
        add(1,0,8'h00, 0,0,0,1); add(1,0,8'h00, 0,0,0,1);
        for (int i = 0; i < 5; i++) add(0,0,8'h00, 0,0,0,1);
        add(1,1,8'hFF, 0,0,0,1);
        // Single word 1101_0110
        add(0,1,8'hD6, 1,1,0,0);
        add(0,0,8'h00, 1,1,0,0); add(0,0,8'h00, 0,1,0,0); add(0,0,8'h00, 1,1,0,0);
        add(0,0,8'h00, 0,1,0,0); add(0,0,8'h00, 1,1,0,0); add(0,0,8'h00, 1,1,0,0);
        add(0,0,8'h00, 0,1,1,1);
        add(0,0,8'h00, 0,0,0,1);
        // Back-to-back 0x0D then 0xD0, load held high through the first word
        add(0,1,8'h0D, 0,1,0,0);
        add(0,1,8'h0D, 0,1,0,0); add(0,1,8'h0D, 0,1,0,0); add(0,1,8'h0D, 0,1,0,0);
        add(0,1,8'h0D, 1,1,0,0); add(0,1,8'h0D, 1,1,0,0); add(0,1,8'h0D, 0,1,0,0);
        add(0,1,8'h0D, 1,1,1,1);
        add(0,1,8'hD0, 1,1,0,0);
        add(0,0,8'h00, 1,1,0,0); add(0,0,8'h00, 0,1,0,0); add(0,0,8'h00, 1,1,0,0);
        add(0,0,8'h00, 0,1,0,0); add(0,0,8'h00, 0,1,0,0); add(0,0,8'h00, 0,1,0,0);
        add(0,0,8'h00, 0,1,1,1);
        add(0,0,8'h00, 0,0,0,1);
        // Load while busy is ignored
        add(0,1,8'hFF, 1,1,0,0);
        add(0,0,8'h00, 1,1,0,0); add(0,0,8'h00, 1,1,0,0); add(0,1,8'h00, 1,1,0,0);
        add(0,0,8'h00, 1,1,0,0); add(0,0,8'h00, 1,1,0,0); add(0,0,8'h00, 1,1,0,0);
        add(0,0,8'h00, 1,1,1,1);
        add(0,0,8'h00, 0,0,0,1);
        // Reset mid-word on 0xB5, then 0x80
        add(0,1,8'hB5, 1,1,0,0);
        add(0,0,8'h00, 0,1,0,0); add(0,0,8'h00, 1,1,0,0); add(0,0,8'h00, 1,1,0,0);
        add(1,0,8'h00, 0,0,0,1);
        add(0,1,8'h80, 1,1,0,0);
        for (int i = 0; i < 6; i++) add(0,0,8'h00, 0,1,0,0);
        add(0,0,8'h00, 0,1,1,1);
        add(0,0,8'h00, 0,0,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].ld, vecs[i].d, 1'b0, 4'h0);
            check($sformatf("vec%0d_out", i), out, vecs[i].e_out);
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_done", i), done, vecs[i].e_done);
            check($sformatf("vec%0d_ready", i), ready, vecs[i].e_ready);
        end

        // WIDTH=4 build: 1011
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 8'h00, (i == 0), 4'b1011);
            check($sformatf("w4_%0d_out", i), out4, w4_out[i]);
            check($sformatf("w4_%0d_valid", i), out_valid4, w4_valid[i]);
            check($sformatf("w4_%0d_done", i), done4, w4_done[i]);
            check($sformatf("w4_%0d_ready", i), ready4, w4_ready[i]);
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), W'($urandom),
                  1'b0, 4'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
